// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: client requests, master command and bus-monitor signals of the arbiter
interface i2c_master_arbiter_if;
    logic        REQ0, REQ1, RNW0, RNW1;
    logic [6:0]  ADDR0, ADDR1;
    logic [15:0] WDATA0, WDATA1;
    logic        GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY, START_STB, RNW;
    logic [6:0]  I2c_addr_master;
    logic [15:0] Wr_data_master;
    logic        SCL, SDA_OUT, SDA_OE;
    modport master (
        input  REQ0, REQ1, RNW0, RNW1, ADDR0, ADDR1, WDATA0, WDATA1, SCL, SDA_OUT, SDA_OE,
        output GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY, START_STB, RNW, I2c_addr_master, Wr_data_master
    );
    modport slave (
        output REQ0, REQ1, RNW0, RNW1, ADDR0, ADDR1, WDATA0, WDATA1, SCL, SDA_OUT, SDA_OE,
        input  GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY, START_STB, RNW, I2c_addr_master, Wr_data_master
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin two-client sequencer for master_i2c with STOP detection, bus-free gap and watchdog
module i2c_master_arbiter #(
    parameter int TIMEOUT = 4000,
    parameter int TO_W    = 12,
    parameter int T_BUF   = 4
) (
    input logic CLK,
    input logic RESET,
    i2c_master_arbiter_if.master bus
);
    localparam int GW = $clog2(T_BUF) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_STOP, GAP} state_t;
    state_t          state_q, state_d;
    logic            sel_q, sel_d, last_q, last_d, armed_q, armed_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            scl_q, scl_p_q, sda_q, sda_p_q;
    logic            rnw_q, rnw_d;
    logic [6:0]      addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [1:0]      done_q, done_d, err_q, err_d;
    logic            own, stop;

    assign own  = state_q inside {LOAD, START, WAIT_STOP};
    assign stop = scl_q & scl_p_q & sda_q & ~sda_p_q;

    assign bus.GNT0            = own & ~sel_q;
    assign bus.GNT1            = own & sel_q;
    assign bus.DONE0           = done_q[0];
    assign bus.DONE1           = done_q[1];
    assign bus.ERR0            = err_q[0];
    assign bus.ERR1            = err_q[1];
    assign bus.BUSY            = state_q != IDLE;
    assign bus.START_STB       = state_q == START;
    assign bus.RNW             = rnw_q;
    assign bus.I2c_addr_master = addr_q;
    assign bus.Wr_data_master  = wdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            armed_q <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
            scl_q   <= 1'b1;
            scl_p_q <= 1'b1;
            sda_q   <= 1'b1;
            sda_p_q <= 1'b1;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            scl_q   <= bus.SCL;
            scl_p_q <= scl_q;
            sda_q   <= bus.SDA_OE ? bus.SDA_OUT : 1'b1;
            sda_p_q <= sda_q;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        armed_d = armed_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: if (bus.REQ0 | bus.REQ1) begin
                sel_d   = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;
                state_d = LOAD;
            end
            LOAD: begin
                rnw_d   = sel_q ? bus.RNW1 : bus.RNW0;
                addr_d  = sel_q ? bus.ADDR1 : bus.ADDR0;
                wdata_d = sel_q ? bus.WDATA1 : bus.WDATA0;
                last_d  = sel_q;
                state_d = START;
            end
            START: begin
                wd_d    = '0;
                armed_d = 1'b0;
                state_d = WAIT_STOP;
            end
            WAIT_STOP: begin
                wd_d    = wd_q + 1'b1;
                armed_d = armed_q | ~scl_q;
                // a STOP only counts once SCL has toggled, so the START-time SDA wiggle is ignored
                if (stop & armed_q) begin
                    done_d  = sel_q ? 2'b10 : 2'b01;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = sel_q ? 2'b10 : 2'b01;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = (gap_q == GW'(T_BUF - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: randomized scenario bench with a rule-level timing and round-robin model
module tb_i2c_master_arbiter;
    localparam int TO = 50;
    localparam int TB = 4;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int cyc = 0, n_chk = 0, n_fail = 0;
    int m_last = 1;
    bit prev_g0, prev_g1;
    bit        e_rnw[2];
    bit [6:0]  e_addr[2];
    bit [15:0] e_data[2];

    i2c_master_arbiter_if bus();
    i2c_master_arbiter #(.TIMEOUT(TO), .TO_W(6), .T_BUF(TB)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    // grant/done ownership rules checked continuously
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            n_chk++;
            if ((bus.GNT0 & bus.GNT1) | ((bus.DONE0 | bus.ERR0) & ~prev_g0) | ((bus.DONE1 | bus.ERR1) & ~prev_g1) |
                ((bus.DONE0 | bus.ERR0) & (bus.DONE1 | bus.ERR1)) | (bus.DONE0 & bus.ERR0) | (bus.DONE1 & bus.ERR1)) begin
                n_fail++;
                $display("FAIL ownership @%0d: gnt=%b%b done=%b%b err=%b%b prev_gnt=%b%b, required one owner and pulses only for it",
                         cyc, bus.GNT1, bus.GNT0, bus.DONE1, bus.DONE0, bus.ERR1, bus.ERR0, prev_g1, prev_g0);
            end
        end
        prev_g0 = bus.GNT0;
        prev_g1 = bus.GNT1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic bus_idle();
        bus.SCL = 1'b1;
        bus.SDA_OE = 1'b0;
        bus.SDA_OUT = 1'b1;
    endtask

    task automatic set_cmd(input int c, input bit r, input bit [6:0] a, input bit [15:0] d);
        e_rnw[c] = r;
        e_addr[c] = a;
        e_data[c] = d;
        if (c == 0) begin
            bus.RNW0 = r; bus.ADDR0 = a; bus.WDATA0 = d;
        end else begin
            bus.RNW1 = r; bus.ADDR1 = a; bus.WDATA1 = d;
        end
    endtask

    task automatic rand_cmd(input int c);
        set_cmd(c, 1'($urandom), 7'($urandom), 16'($urandom));
    endtask

    // START, data pulses, STOP; the STOP's SDA rise is driven in the cycle numbered cyc on return
    task automatic frame(input int pulses);
        tick; bus.SDA_OE = 1'b1; bus.SDA_OUT = 1'b0;
        for (int i = 0; i < pulses; i++) begin
            tick; bus.SCL = 1'b0; bus.SDA_OUT = 1'($urandom);
            tick; bus.SCL = 1'b1;
        end
        tick; bus.SCL = 1'b0; bus.SDA_OUT = 1'b0;
        tick; bus.SCL = 1'b1;
        tick; bus.SDA_OE = 1'b0;
    endtask

    task automatic wait_stb(output int c);
        c = -1;
        for (int i = 0; i < 20 && c < 0; i++) begin
            tick;
            if (bus.START_STB) c = cyc;
        end
    endtask

    function automatic int winner(input bit r0, input bit r1);
        return (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
    endfunction

    function automatic logic [31:0] all_outs();
        return {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.ERR0, bus.ERR1, bus.BUSY, bus.START_STB,
                bus.RNW, bus.I2c_addr_master, bus.Wr_data_master};
    endfunction

    function automatic logic [23:0] cmd_out();
        return {bus.RNW, bus.I2c_addr_master, bus.Wr_data_master};
    endfunction

    task automatic test_reset();
        RESET = 1'b1; bus_idle; bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        rand_cmd(0); rand_cmd(1);
        tick; tick;
        n_chk++;
        if (all_outs() !== 32'd0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_outs()); end
        RESET = 1'b0; m_last = 1;
        tick;
        n_chk++;
        if (all_outs() !== 32'd0) begin n_fail++; $display("FAIL idle_no_req: got %h, required 0", all_outs()); end
    endtask

    task automatic test_single();
        set_cmd(0, 1'b0, 7'h2A, 16'hA5C3);
        bus.REQ0 = 1'b1;
        tick;
        n_chk++;
        if ({bus.GNT0, bus.GNT1, bus.BUSY, bus.START_STB} !== 4'b1010) begin
            n_fail++; $display("FAIL single_gnt: gnt0,gnt1,busy,stb=%b, required 1010", {bus.GNT0, bus.GNT1, bus.BUSY, bus.START_STB});
        end
        tick;
        n_chk++;
        if ({bus.START_STB, bus.GNT0, cmd_out()} !== {2'b11, 1'b0, 7'h2A, 16'hA5C3}) begin
            n_fail++; $display("FAIL single_stb: stb=%b gnt0=%b cmd=%h, required 1 1 %h", bus.START_STB, bus.GNT0, cmd_out(), {1'b0, 7'h2A, 16'hA5C3});
        end
        frame($urandom_range(2, 12));
        tick;
        n_chk++;
        if (bus.DONE0 !== 1'b0) begin n_fail++; $display("FAIL single_done_early: done0=%b, required 0", bus.DONE0); end
        tick;
        n_chk++;
        if ({bus.DONE0, bus.GNT0} !== 2'b10) begin n_fail++; $display("FAIL single_done: done0,gnt0=%b, required 10", {bus.DONE0, bus.GNT0}); end
        bus.REQ0 = 1'b0; m_last = 0;
        tick;
        n_chk++;
        if (bus.DONE0 !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: done0=%b, required 0", bus.DONE0); end
        tick; tick;
        n_chk++;
        if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL single_gap_busy: busy=%b, required 1", bus.BUSY); end
        tick;
        n_chk++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL single_gap_end: busy=%b, required 0", bus.BUSY); end
    endtask

    task automatic test_back_to_back();
        int s, dcyc, exp;
        RESET = 1'b1; tick; RESET = 1'b0; m_last = 1;
        rand_cmd(0); rand_cmd(1);
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        dcyc = -1;
        for (int i = 0; i < 4; i++) begin
            exp = winner(1'b1, 1'b1);
            wait_stb(s);
            n_chk++;
            if (s < 0) begin n_fail++; $display("FAIL b2b_stb_timeout: txn %0d no START_STB within 20 cycles", i); return; end
            if (i > 0) begin
                n_chk++;
                if (s - dcyc !== 6) begin n_fail++; $display("FAIL b2b_spacing: txn %0d got %0d cycles, required 6", i, s - dcyc); end
            end
            n_chk++;
            if ({bus.GNT1, bus.GNT0} !== (exp == 1 ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL b2b_grant: txn %0d gnt1,gnt0=%b, required client %0d", i, {bus.GNT1, bus.GNT0}, exp);
            end
            n_chk++;
            if (cmd_out() !== {e_rnw[exp], e_addr[exp], e_data[exp]}) begin
                n_fail++; $display("FAIL b2b_cmd: txn %0d cmd=%h, required %h", i, cmd_out(), {e_rnw[exp], e_addr[exp], e_data[exp]});
            end
            frame($urandom_range(2, 10));
            tick; tick;
            n_chk++;
            if ((exp == 1 ? bus.DONE1 : bus.DONE0) !== 1'b1) begin
                n_fail++; $display("FAIL b2b_done: txn %0d done1,done0=%b, required client %0d", i, {bus.DONE1, bus.DONE0}, exp);
            end
            dcyc = cyc; m_last = exp;
            rand_cmd(exp);
        end
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        repeat (TB + 1) tick;
        n_chk++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b, required 0", bus.BUSY); end
    endtask

    task automatic test_timeout();
        int s, e;
        bit saw_done;
        rand_cmd(1);
        bus.REQ1 = 1'b1;
        wait_stb(s);
        e = -1; saw_done = 1'b0;
        for (int i = 0; i < 80 && e < 0; i++) begin
            tick;
            if (bus.DONE1) saw_done = 1'b1;
            if (bus.ERR1) e = cyc;
        end
        bus.REQ1 = 1'b0; m_last = 1;
        n_chk++;
        if (s < 0 || e - s !== TO + 1) begin n_fail++; $display("FAIL timeout_latency: stb@%0d err@%0d, required gap %0d", s, e, TO + 1); end
        n_chk++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL timeout_no_done: done1 seen=%b, required 0", saw_done); end
        n_chk++;
        if ({bus.GNT1, cmd_out()} !== {1'b0, e_rnw[1], e_addr[1], e_data[1]}) begin
            n_fail++; $display("FAIL timeout_hold: gnt1=%b cmd=%h, required 0 %h", bus.GNT1, cmd_out(), {e_rnw[1], e_addr[1], e_data[1]});
        end
        repeat (TB - 1) tick;
        n_chk++;
        if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL timeout_gap_busy: busy=%b, required 1", bus.BUSY); end
        tick;
        n_chk++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b, required 0", bus.BUSY); end
    endtask

    task automatic test_false_stop();
        int s;
        bit bad;
        rand_cmd(0);
        bus.REQ0 = 1'b1;
        wait_stb(s);
        tick; bus.SDA_OE = 1'b1; bus.SDA_OUT = 1'b0;
        tick;
        tick; bus.SDA_OE = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            tick;
            if (bus.DONE0 || !bus.GNT0) bad = 1'b1;
        end
        n_chk++;
        if (s < 0 || bad) begin n_fail++; $display("FAIL false_stop: stb@%0d early completion=%b, required none", s, bad); end
        frame($urandom_range(2, 8));
        tick; tick;
        n_chk++;
        if (bus.DONE0 !== 1'b1) begin n_fail++; $display("FAIL false_stop_real: done0=%b, required 1", bus.DONE0); end
        bus.REQ0 = 1'b0; m_last = 0;
        repeat (TB + 1) tick;
    endtask

    task automatic test_reset_mid();
        int s;
        rand_cmd(0); rand_cmd(1);
        bus.REQ0 = 1'b1;
        wait_stb(s);
        tick; bus.SCL = 1'b0;
        tick; bus.SCL = 1'b1;
        tick; RESET = 1'b1;
        tick;
        n_chk++;
        if (all_outs() !== 32'd0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h, required 0", all_outs()); end
        RESET = 1'b0; bus_idle; m_last = 1;
        bus.REQ1 = 1'b1;
        tick;
        n_chk++;
        if ({bus.GNT1, bus.GNT0} !== (winner(1'b1, 1'b1) == 1 ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL reset_mid_tie: gnt1,gnt0=%b, required client %0d", {bus.GNT1, bus.GNT0}, winner(1'b1, 1'b1));
        end
        wait_stb(s);
        frame(3);
        tick; tick;
        n_chk++;
        if (bus.DONE0 !== 1'b1) begin n_fail++; $display("FAIL reset_mid_done: done0=%b, required 1", bus.DONE0); end
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; m_last = 0;
        repeat (TB + 1) tick;
    endtask

    task automatic test_read();
        int s;
        bit stable;
        logic [23:0] want;
        set_cmd(1, 1'b1, 7'h55, 16'($urandom));
        bus.REQ1 = 1'b1;
        wait_stb(s);
        want = {1'b1, 7'h55, e_data[1]};
        n_chk++;
        if (s < 0 || cmd_out() !== want) begin n_fail++; $display("FAIL read_cmd: cmd=%h, required %h", cmd_out(), want); end
        bus.RNW1 = 1'b0; bus.ADDR1 = 7'($urandom); bus.WDATA1 = 16'($urandom);
        stable = 1'b1;
        repeat (3) begin
            tick;
            if (cmd_out() !== want) stable = 1'b0;
        end
        frame($urandom_range(2, 8));
        tick; tick;
        n_chk++;
        if (bus.DONE1 !== 1'b1) begin n_fail++; $display("FAIL read_done: done1=%b, required 1", bus.DONE1); end
        bus.REQ1 = 1'b0; m_last = 1;
        repeat (TB + 3) begin
            if (cmd_out() !== want) stable = 1'b0;
            tick;
        end
        n_chk++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL read_hold: cmd=%h, required %h held", cmd_out(), want); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_false_stop();
        test_reset_mid();
        test_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
